// File: rtl/keygen_mq_montyred_pipe.sv
// Three-stage streaming Montgomery reduction (q = 12289, R = 2^16) with whole-pipe stall.
// Optional output-transfer counter enabled by defining KEYGEN_MQ_MONTYRED_STATS_EN.
module keygen_mq_montyred_pipe #(
  parameter int unsigned IN_W  = 28,
  parameter int unsigned Q     = 12289,
  parameter int unsigned Q0I   = 12287,
  parameter int unsigned OUT_W = 14
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data
`ifdef KEYGEN_MQ_MONTYRED_STATS_EN
  ,
  output logic [31:0]      stat_count
`endif
);

  localparam int unsigned S_W = IN_W + 2;
  localparam int unsigned R_W = S_W - 16;
  localparam logic [15:0]    Q0I_L = 16'(Q0I);
  localparam logic [S_W-1:0] Q_S   = S_W'(Q);
  localparam logic [R_W-1:0] Q_R   = R_W'(Q);

  logic             v1, v2, v3;
  logic [IN_W-1:0]  z1;
  logic [15:0]      t1;
  logic [S_W-1:0]   s2;
  logic [R_W-1:0]   r_c;
  logic             adv_c;

  // The whole pipe advances unless the last stage is full and blocked.
  assign adv_c     = ~v3 | out_ready;
  assign in_ready  = adv_c;
  assign out_valid = v3;

  // Low 16 bits of s2 are zero by construction of t1; only the quotient matters.
  assign r_c = R_W'(s2 >> 16);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v1       <= 1'b0;
      v2       <= 1'b0;
      v3       <= 1'b0;
      z1       <= '0;
      t1       <= '0;
      s2       <= '0;
      out_data <= '0;
    end else if (flush) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
    end else if (adv_c) begin
      v1 <= in_valid;
      v2 <= v1;
      v3 <= v2;
      if (in_valid) begin
        z1 <= in_data;
        t1 <= in_data[15:0] * Q0I_L;
      end
      if (v1) begin
        s2 <= S_W'(z1) + S_W'(t1) * Q_S;
      end
      if (v2) begin
        out_data <= OUT_W'((r_c >= Q_R) ? (r_c - Q_R) : r_c);
      end
    end
  end

`ifdef KEYGEN_MQ_MONTYRED_STATS_EN
  // Counts output transfers; flush wins over a same-cycle transfer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_count <= '0;
    end else if (flush) begin
      stat_count <= '0;
    end else if (v3 && out_ready) begin
      stat_count <= stat_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_keygen_mq_montyred_pipe.sv
// Scoreboard bench for keygen_mq_montyred_pipe: directed vectors, stall, bubbles, flush, reset, random.
module tb_keygen_mq_montyred_pipe;

  localparam int unsigned IN_W  = 28;
  localparam int unsigned OUT_W = 14;
  localparam longint      QM    = 12289;

  logic             clk = 1'b0;
  logic             reset;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
`ifdef KEYGEN_MQ_MONTYRED_STATS_EN
  logic [31:0]      stat_count;
`endif

  keygen_mq_montyred_pipe dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef KEYGEN_MQ_MONTYRED_STATS_EN
    ,
    .stat_count(stat_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [OUT_W-1:0] exp;
    int               cyc;
    bit               lat;
  } item_t;

  item_t  sb[$];
  item_t  mon_it;
  int     n_cmp = 0;
  int     n_err = 0;
  int     cyc   = 0;
  bit     rnd_on = 1'b0;
  longint rinv = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Independent reference: z * R^-1 mod q using a searched modular inverse.
  function automatic logic [OUT_W-1:0] mont(input longint z);
    return OUT_W'(((z % QM) * rinv) % QM);
  endfunction

  // Monitor: every output transfer pops and checks one scoreboard entry.
  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_out: got data %0d with empty scoreboard (t=%0t)", out_data, $time);
      end else begin
        mon_it = sb.pop_front();
        check("out_data", 32'(out_data), 32'(mon_it.exp));
        if (mon_it.lat) check("latency", 32'(cyc - mon_it.cyc), 32'd3);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [IN_W-1:0] z, input logic [OUT_W-1:0] e, input bit lat);
    bit acc   = 1'b0;
    int guard = 0;
    in_valid = 1'b1;
    in_data  = z;
    while (!acc) begin
      @(negedge clk);
      if (in_ready && !flush) begin
        acc = 1'b1;
        sb.push_back('{e, cyc, lat});
      end
      @(posedge clk);
      #1;
      guard++;
      if (!acc && guard > 1000) begin
        n_cmp++;
        n_err++;
        $display("FAIL send_timeout: input %0d not accepted", z);
        acc = 1'b1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int g = 0;
    while (sb.size() != 0 && g < 5000) begin
      @(posedge clk);
      #1;
      g++;
    end
    check("drain", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [IN_W-1:0] zs [8];
    reset     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    for (longint x = 1; x < QM; x++) if (((x * 65536) % QM) == 1) rinv = x;

    // Reset values
    #3;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef KEYGEN_MQ_MONTYRED_STATS_EN
    check("rst_stat", stat_count, 32'd0);
`endif
    idle(2);
    reset = 1'b1;
    idle(1);

    // Basic hand-computed vectors, back-to-back, latency 3
    send(28'd0,         14'd0,    1'b1);
    send(28'd65536,     14'd1,    1'b1);
    send(28'd12289,     14'd0,    1'b1);
    send(28'd150994944, 14'd2304, 1'b1);
    wait_drain();

    // Back-pressure: stall 5 cycles once the first result is presented
    for (int i = 0; i < 8; i++) zs[i] = IN_W'(((i + 1) * 1187) * (12288 - i * 1301));
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) send(zs[i], mont(longint'(zs[i])), 1'b0);
      end
      begin
        int g = 0;
        do begin
          @(negedge clk);
          g++;
        end while (!out_valid && g < 50);
        for (int k = 0; k < 5; k++) begin
          if (k > 0) @(negedge clk);
          check("bp_valid", 32'(out_valid), 32'd1);
          check("bp_hold_data", 32'(out_data), 32'(mont(longint'(zs[0]))));
          check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    wait_drain();

    // Bubbles: alternating input valid keeps the same pattern at the output
    for (int i = 0; i < 6; i++) begin
      send(IN_W'(i * 20011 + 3), mont(longint'(i * 20011 + 3)), 1'b1);
      idle(1);
    end
    wait_drain();

    // Flush with three items in flight; first one transfers in the flush cycle
    send(28'd131072, 14'd2, 1'b0);
    send(28'd196608, 14'd3, 1'b0);
    send(28'd262144, 14'd4, 1'b0);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 28'd12345;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    @(negedge clk);
    check("flush_out_valid", 32'(out_valid), 32'd0);
`ifdef KEYGEN_MQ_MONTYRED_STATS_EN
    check("flush_stat", stat_count, 32'd0);
`endif
    @(posedge clk);
    #1;
    idle(5);
    send(28'd327680, 14'd5, 1'b1);
    wait_drain();
`ifdef KEYGEN_MQ_MONTYRED_STATS_EN
    check("stat_after_flush", stat_count, 32'd1);
`endif

    // Asynchronous reset between edges with items in flight
    send(28'd393216, 14'd6, 1'b0);
    send(28'd458752, 14'd7, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    check("async_out_valid", 32'(out_valid), 32'd0);
    check("async_out_data", 32'(out_data), 32'd0);
    check("async_in_ready", 32'(in_ready), 32'd1);
`ifdef KEYGEN_MQ_MONTYRED_STATS_EN
    check("async_stat", stat_count, 32'd0);
`endif
    sb.delete();
    idle(2);
    #3;
    reset = 1'b1;
    idle(4);
    send(28'd524288, 14'd8, 1'b1);
    wait_drain();

    // Random products with random back-pressure
    flush = 1'b1;
    idle(1);
    flush  = 1'b0;
    rnd_on = 1'b1;
    fork
      begin
        for (int i = 0; i < 10000; i++) begin
          longint a = longint'($urandom_range(0, 12288));
          longint b = longint'($urandom_range(0, 12288));
          send(IN_W'(a * b), mont(a * b), 1'b0);
        end
        rnd_on = 1'b0;
      end
      begin
        while (rnd_on) begin
          out_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    wait_drain();
`ifdef KEYGEN_MQ_MONTYRED_STATS_EN
    check("stat_random", stat_count, 32'd10000);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
